// File: rtl/mc_control_unit_if.sv
// Bus between the multicycle controller and the instruction register / shared-ALU datapath.
// master: the controller (consumes instr and the ALU zero flag, drives selects and enables).
// slave:  the datapath side.
interface mc_control_unit_if;
    logic [31:0] instr;
    logic        aluflags;
    logic        pcwrite;
    logic        irwrite;
    logic        memwrite;
    logic        regwrite;
    logic        adrsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  resultsrc;
    logic [1:0]  immsrc;
    logic        alucontrol;

    modport master (
        input  instr, aluflags,
        output pcwrite, irwrite, memwrite, regwrite, adrsrc, alusrca,
               alusrcb, resultsrc, immsrc, alucontrol
    );

    modport slave (
        output instr, aluflags,
        input  pcwrite, irwrite, memwrite, regwrite, adrsrc, alusrca,
               alusrcb, resultsrc, immsrc, alucontrol
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle controller: decodes the instruction register and steps a Moore FSM that
// drives the ALU command, the datapath mux selects and the write enables.
// Optional feature macro COND_EXEC_EN: when defined, a Z flag register and EQ/NE/AL
// condition evaluation are built; when undefined every instruction executes as AL.
module mc_control_unit (
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.master  bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    logic       cond_ok_s;
    logic       is_cmp_s;
    logic       alu_sub_s;
    logic       alu_wb_s;

    logic       pcwrite_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       adrsrc_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] resultsrc_s;
    logic       alucontrol_s;

    // Command field is Funct[4:1]; only ADD and SUB write back, CMP shares the SUB path.
    assign is_cmp_s  = (bus.instr[24:21] == CMD_CMP);
    assign alu_sub_s = (bus.instr[24:21] == CMD_SUB) || is_cmp_s;
    assign alu_wb_s  = (bus.instr[24:21] == CMD_ADD) || (bus.instr[24:21] == CMD_SUB);

`ifdef COND_EXEC_EN
    logic z_r;
    logic cond_ok_r;

    // Condition code check against the flag value held before this instruction.
    function automatic logic cond_eval(input logic [3:0] cond, input logic z);
        logic ok;
        case (cond)
            4'b0000: ok = z;
            4'b0001: ok = ~z;
            4'b1110: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Z flag: captured leaving an execute state when the instruction passed and sets flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_r <= 1'b0;
        end else if (((state_r == S_EXECR) || (state_r == S_EXECI)) && cond_ok_r &&
                     (bus.instr[20] || is_cmp_s)) begin
            z_r <= bus.aluflags;
        end
    end

    // Condition result: latched at the end of DECODE and held for the whole instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_ok_r <= 1'b1;
        end else if (state_r == S_DECODE) begin
            cond_ok_r <= cond_eval(bus.instr[31:28], z_r);
        end
    end

    assign cond_ok_s = cond_ok_r;
`else
    assign cond_ok_s = 1'b1;
`endif

    // State register; reset lands in FETCH so the first fetch follows reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; any unused encoding falls back to FETCH.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (bus.instr[27:26])
                    2'b00:   next_state_s = bus.instr[25] ? S_EXECI : S_EXECR;
                    2'b01:   next_state_s = S_MEMADR;
                    2'b10:   next_state_s = S_BRANCH;
                    default: next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: next_state_s = bus.instr[20] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state_s = S_MEMWB;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = S_FETCH;
            S_EXECR:  next_state_s = S_ALUWB;
            S_EXECI:  next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode; a failed condition only masks the architectural write.
    always_comb begin
        pcwrite_s    = 1'b0;
        irwrite_s    = 1'b0;
        memwrite_s   = 1'b0;
        regwrite_s   = 1'b0;
        adrsrc_s     = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        resultsrc_s  = 2'b00;
        alucontrol_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                irwrite_s   = 1'b1;
                pcwrite_s   = 1'b1;
                alusrca_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
            end
            S_DECODE: begin
                alusrca_s   = 1'b1;
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
            end
            S_MEMADR: alusrcb_s = 2'b01;
            S_MEMRD:  adrsrc_s  = 1'b1;
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = cond_ok_s;
            end
            S_MEMWR: begin
                adrsrc_s   = 1'b1;
                memwrite_s = cond_ok_s;
            end
            S_EXECR: alucontrol_s = alu_sub_s;
            S_EXECI: begin
                alusrcb_s    = 2'b01;
                alucontrol_s = alu_sub_s;
            end
            S_ALUWB: regwrite_s = cond_ok_s & alu_wb_s;
            S_BRANCH: begin
                alusrcb_s   = 2'b01;
                resultsrc_s = 2'b10;
                pcwrite_s   = cond_ok_s;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    // Enables are held off asynchronously while reset is asserted.
    assign bus.pcwrite    = pcwrite_s  & ~reset;
    assign bus.irwrite    = irwrite_s  & ~reset;
    assign bus.memwrite   = memwrite_s & ~reset;
    assign bus.regwrite   = regwrite_s & ~reset;
    assign bus.adrsrc     = adrsrc_s;
    assign bus.alusrca    = alusrca_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.resultsrc  = resultsrc_s;
    assign bus.immsrc     = bus.instr[27:26];
    assign bus.alucontrol = alucontrol_s;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit. Each cycle's outputs are packed as
// {pcwrite,irwrite,memwrite,regwrite}_adrsrc_alusrca_alusrcb_resultsrc_alucontrol
// and compared against hand-written per-state vectors.
module tb_mc_control_unit;
    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef COND_EXEC_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    // Hand-written per-state output vectors.
    localparam logic [10:0] S0   = 11'b1100_0_1_10_10_0;
    localparam logic [10:0] S1   = 11'b0000_0_1_10_10_0;
    localparam logic [10:0] RST  = 11'b0000_0_1_10_10_0;
    localparam logic [10:0] S2   = 11'b0000_0_0_01_00_0;
    localparam logic [10:0] S3   = 11'b0000_1_0_00_00_0;
    localparam logic [10:0] S4W  = 11'b0001_0_0_00_01_0;
    localparam logic [10:0] S5W  = 11'b0010_1_0_00_00_0;
    localparam logic [10:0] S6A  = 11'b0000_0_0_00_00_0;
    localparam logic [10:0] S6S  = 11'b0000_0_0_00_00_1;
    localparam logic [10:0] S7A  = 11'b0000_0_0_01_00_0;
    localparam logic [10:0] S8W  = 11'b0001_0_0_00_00_0;
    localparam logic [10:0] S8N  = 11'b0000_0_0_00_00_0;
    localparam logic [10:0] S9P  = 11'b1000_0_0_01_10_0;
    localparam logic [10:0] S9N  = 11'b0000_0_0_01_10_0;

    logic [10:0] obs_s;
    assign obs_s = {bus.pcwrite, bus.irwrite, bus.memwrite, bus.regwrite, bus.adrsrc,
                    bus.alusrca, bus.alusrcb, bus.resultsrc, bus.alucontrol};

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct);
        return {cond, op, funct, 20'h00000};
    endfunction

    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [10:0] e [$] = '{S0, S1, S2, S5W};
        #3;
        vec_cnt++;
        if (obs_s !== RST) begin
            err_cnt++;
            $display("FAIL reset_hold: outputs %b, expected %b", obs_s, RST);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.instr = mk(AL, 2'b01, 6'b000000);
        foreach (e[i]) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL reset_str cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        vec_cnt++;
        if (obs_s !== RST) begin
            err_cnt++;
            $display("FAIL reset_async_memwr: outputs %b, expected %b", obs_s, RST);
        end
        @(posedge clk); #1;
        vec_cnt++;
        if (obs_s !== RST) begin
            err_cnt++;
            $display("FAIL reset_held_edge: outputs %b, expected %b", obs_s, RST);
        end
        reset = 1'b0;
        bus.instr = mk(AL, 2'b11, 6'b000000);
        e = '{S0, S1};
        foreach (e[i]) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL reset_release cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_reg();
        logic [31:0] ins [$] = '{mk(AL, 2'b00, 6'b001000), mk(AL, 2'b00, 6'b101000),
                                 mk(AL, 2'b00, 6'b000000), mk(AL, 2'b11, 6'b000000)};
        logic        fl  [$] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [10:0] e   [$] = '{S0, S1, S6A, S8W, S0, S1, S7A, S8W,
                                 S0, S1, S6A, S8N, S0, S1};
        int k = -1;
        foreach (e[i]) begin
            if (e[i] == S0) begin
                k++;
                bus.instr    = ins[k];
                bus.aluflags = fl[k];
            end
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL add_reg cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cmp_beq();
        logic [31:0] ins [$] = '{mk(AL, 2'b00, 6'b010101), mk(EQ, 2'b10, 6'b000000),
                                 mk(AL, 2'b00, 6'b010101), mk(EQ, 2'b10, 6'b000000)};
        logic        fl  [$] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [10:0] e   [$] = '{S0, S1, S6S, S8N, S0, S1, S9P,
                                 S0, S1, S6S, S8N, S0, S1, (CE ? S9N : S9P)};
        int k = -1;
        foreach (e[i]) begin
            if (e[i] == S0) begin
                k++;
                bus.instr    = ins[k];
                bus.aluflags = fl[k];
            end
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL cmp_beq cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldr_str();
        logic [31:0] ins [$] = '{mk(AL, 2'b01, 6'b000001), mk(AL, 2'b01, 6'b000000)};
        logic [10:0] e   [$] = '{S0, S1, S2, S3, S4W, S0, S1, S2, S5W};
        int k = -1;
        foreach (e[i]) begin
            if (e[i] == S0) begin
                k++;
                bus.instr    = ins[k];
                bus.aluflags = 1'b0;
            end
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL ldr_str cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
            vec_cnt++;
            if (bus.immsrc !== 2'b01) begin
                err_cnt++;
                $display("FAIL ldr_str_immsrc cyc %0d: immsrc %b, expected 01", i, bus.immsrc);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_subne();
        logic [31:0] ins [$] = '{mk(AL, 2'b00, 6'b010101), mk(NE, 2'b00, 6'b000100)};
        logic        fl  [$] = '{1'b1, 1'b0};
        logic [10:0] e   [$] = '{S0, S1, S6S, S8N, S0, S1, S6S, (CE ? S8N : S8W)};
        int k = -1;
        foreach (e[i]) begin
            if (e[i] == S0) begin
                k++;
                bus.instr    = ins[k];
                bus.aluflags = fl[k];
            end
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL subne cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_subs_eq();
        logic [31:0] ins [$] = '{mk(AL, 2'b00, 6'b010101), mk(EQ, 2'b00, 6'b001000),
                                 mk(AL, 2'b00, 6'b000101), mk(EQ, 2'b00, 6'b001000)};
        logic        fl  [$] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [10:0] e   [$] = '{S0, S1, S6S, S8N, S0, S1, S6A, (CE ? S8N : S8W),
                                 S0, S1, S6S, S8W, S0, S1, S6A, S8W};
        int k = -1;
        foreach (e[i]) begin
            if (e[i] == S0) begin
                k++;
                bus.instr    = ins[k];
                bus.aluflags = fl[k];
            end
            @(negedge clk);
            vec_cnt++;
            if (obs_s !== e[i]) begin
                err_cnt++;
                $display("FAIL subs_eq cyc %0d: outputs %b, expected %b", i, obs_s, e[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_cnt      = 0;
        err_cnt      = 0;
        reset        = 1'b1;
        bus.instr    = mk(AL, 2'b11, 6'b000000);
        bus.aluflags = 1'b0;
        test_reset();
        test_add_reg();
        test_cmp_beq();
        test_ldr_str();
        test_subne();
        test_subs_eq();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
